// File: rtl/uart_ram_tx_if.sv
// uart_ram_tx_if: host write port into the uart_ram_tx byte store
interface uart_ram_tx_if #(parameter int AW = 4);
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0] wr_data;
  modport master (output wr_en, wr_addr, wr_data);
  modport slave (input wr_en, wr_addr, wr_data);
endinterface

// File: rtl/uart_ram_tx.sv
// uart_ram_tx: debounced push-button streams a byte RAM out as configurable UART frames
module uart_ram_tx #(
  parameter int RAM_SIZE = 16,
  parameter int CLK_FREQ = 44,
  parameter int BAUD = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int DB_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  input logic BTNTX,
  uart_ram_tx_if.slave wr,
  output logic busy,
  output logic done,
  output logic tx_out
);
  localparam int AW = $clog2(RAM_SIZE);
  localparam int BAUD_DIV = (CLK_FREQ * 1000000) / BAUD;
  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [7:0] MASK = 8'((16'd1 << DATA_BITS) - 16'd1);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PAR, STOP, DONE} state_t;
  state_t state_q;
  logic [7:0] mem_q [RAM_SIZE];
  logic [7:0] ram_dout_q, shift_q;
  logic [AW-1:0] rd_addr_q;
  logic [BW-1:0] baud_q;
  logic [2:0] bit_q;
  logic par_q;
  logic [1:0] sync_q, sync_d;
  logic [DW-1:0] db_q, db_d;
  logic press, baud_end, last;
  always_comb begin
    sync_d = {sync_q[0], BTNTX};
    db_d = !sync_q[1] ? '0 : db_q == DW'(DB_CYCLES) ? db_q : db_q + 1'b1;
    press = sync_q[1] && db_q == DW'(DB_CYCLES - 1);
    baud_end = baud_q == BW'(BAUD_DIV - 1);
    last = rd_addr_q == AW'(RAM_SIZE - 1);
  end
  always_ff @(posedge clk) begin
    sync_q <= rst ? '0 : sync_d;
    db_q <= rst ? '0 : db_d;
  end
  always_ff @(posedge clk) begin
    if (wr.wr_en) mem_q[wr.wr_addr] <= wr.wr_data;
    ram_dout_q <= mem_q[rd_addr_q];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_out <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      rd_addr_q <= '0;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
    end else begin
      baud_q <= (state_q inside {START, DATA, PAR, STOP}) && !baud_end ? baud_q + 1'b1 : '0;
      case (state_q)
        IDLE: if (press) begin
          rd_addr_q <= '0;
          busy <= 1'b1;
          state_q <= FETCH;
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          shift_q <= ram_dout_q;
          par_q <= ^(ram_dout_q & MASK) ^ (PARITY == 1);
          tx_out <= 1'b0;
          state_q <= START;
        end
        START: if (baud_end) begin
          tx_out <= shift_q[0];
          shift_q <= shift_q >> 1;
          bit_q <= '0;
          state_q <= DATA;
        end
        DATA: if (baud_end) begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
            tx_out <= PARITY != 0 ? par_q : 1'b1;
            state_q <= PARITY != 0 ? PAR : STOP;
            bit_q <= '0;
          end else begin
            tx_out <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q <= bit_q + 1'b1;
          end
        end
        PAR: if (baud_end) begin
          tx_out <= 1'b1;
          state_q <= STOP;
        end
        STOP: if (baud_end) begin
          if (bit_q == 3'(STOP_BITS - 1)) begin
            bit_q <= '0;
            done <= last;
            state_q <= last ? DONE : FETCH;
            if (!last) rd_addr_q <= rd_addr_q + 1'b1;
          end else begin
            bit_q <= bit_q + 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_ram_tx.sv
// tb_uart_ram_tx: scoreboard bench over 8N1, 8E1 and 7O2 instances of uart_ram_tx
module tb_uart_ram_tx;
  localparam int DIV = 4;
  localparam int NB [3] = '{8, 8, 7};
  localparam int SB [3] = '{1, 1, 2};
  localparam int HASP [3] = '{0, 1, 1};
  localparam int BL [3] = '{169, 185, 185};
  typedef struct { logic [7:0] d; logic p; logic last; } exp_t;
  logic clk = 1'b0;
  logic [2:0] rst = 3'b111;
  logic [2:0] btn = 3'b000;
  wire [2:0] tx, busy, done;
  exp_t q [3][$];
  int sweeps [3] = '{0, 0, 0};
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  uart_ram_tx_if #(.AW(2)) if0 ();
  uart_ram_tx_if #(.AW(2)) if1 ();
  uart_ram_tx_if #(.AW(2)) if2 ();
  uart_ram_tx #(.RAM_SIZE(4), .CLK_FREQ(1), .BAUD(250000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DB_CYCLES(4)) u0 (
    .clk(clk), .rst(rst[0]), .BTNTX(btn[0]), .wr(if0), .busy(busy[0]), .done(done[0]), .tx_out(tx[0]));
  uart_ram_tx #(.RAM_SIZE(4), .CLK_FREQ(1), .BAUD(250000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DB_CYCLES(4)) u1 (
    .clk(clk), .rst(rst[1]), .BTNTX(btn[1]), .wr(if1), .busy(busy[1]), .done(done[1]), .tx_out(tx[1]));
  uart_ram_tx #(.RAM_SIZE(4), .CLK_FREQ(1), .BAUD(250000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .DB_CYCLES(4)) u2 (
    .clk(clk), .rst(rst[2]), .BTNTX(btn[2]), .wr(if2), .busy(busy[2]), .done(done[2]), .tx_out(tx[2]));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask
  task automatic wr(input int k, input int a, input logic [7:0] d);
    case (k)
      0: begin if0.wr_en = 1'b1; if0.wr_addr = 2'(a); if0.wr_data = d; end
      1: begin if1.wr_en = 1'b1; if1.wr_addr = 2'(a); if1.wr_data = d; end
      default: begin if2.wr_en = 1'b1; if2.wr_addr = 2'(a); if2.wr_data = d; end
    endcase
    tick();
    if0.wr_en = 1'b0;
    if1.wr_en = 1'b0;
    if2.wr_en = 1'b0;
  endtask
  task automatic push(input int k, input logic [7:0] d, input logic p, input logic last);
    exp_t e;
    e.d = d;
    e.p = p;
    e.last = last;
    q[k].push_back(e);
  endtask
  task automatic push_a(input logic [7:0] b3);
    push(0, 8'h55, 1'b0, 1'b0);
    push(0, 8'hA3, 1'b0, 1'b0);
    push(0, 8'h00, 1'b0, 1'b0);
    push(0, b3, 1'b0, 1'b1);
  endtask
  task automatic press(input int k, input int n);
    btn[k] = 1'b1;
    repeat (n) tick();
    btn[k] = 1'b0;
    tick();
  endtask
  task automatic wait_idle(input int k);
    for (int i = 0; i < 3000 && busy[k] !== 1'b0; i++) tick();
    chk($sformatf("idle_timeout%0d", k), {31'd0, busy[k]}, 0);
    repeat (3) tick();
  endtask
  task automatic wait_busy(input int k);
    for (int i = 0; i < 100 && busy[k] !== 1'b1; i++) tick();
    chk($sformatf("busy_timeout%0d", k), {31'd0, busy[k]}, 1);
  endtask
  task automatic get_bit(input int k, input int n, output logic v, inout logic ok, inout logic ab);
    v = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst[k]) ab = 1'b1;
      if (i == 0) v = tx[k];
      else if (tx[k] !== v) ok = 1'b0;
    end
  endtask
  task automatic mon(input int k);
    logic [7:0] d;
    logic p, v, ok, ab, st;
    int run, gap;
    exp_t e;
    st = 1'b0;
    forever begin
      if (!st) begin
        @(negedge clk);
        if (rst[k] || tx[k] !== 1'b0) continue;
      end
      ok = 1'b1;
      ab = 1'b0;
      d = 8'h00;
      p = 1'b0;
      get_bit(k, DIV - 1, v, ok, ab);
      ok = ok && v === 1'b0;
      for (int i = 0; i < NB[k]; i++) begin
        get_bit(k, DIV, v, ok, ab);
        d[i] = v;
      end
      if (HASP[k] != 0) get_bit(k, DIV, p, ok, ab);
      run = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (rst[k]) ab = 1'b1;
        if (tx[k] !== 1'b1 || busy[k] !== 1'b1) break;
        run++;
      end
      st = tx[k] === 1'b0 && !ab;
      if (ab) begin
        q[k].delete();
        continue;
      end
      n_cmp++;
      if (q[k].size() == 0) begin
        n_bad++;
        $display("FAIL frame%0d: unexpected frame data=%h", k, d);
        continue;
      end
      e = q[k].pop_front();
      gap = SB[k] * DIV + (e.last ? 1 : 2);
      if (d !== e.d || p !== e.p || !ok || run != gap) begin
        n_bad++;
        $display("FAIL frame%0d: got data=%h par=%b mark=%0d stable=%b want data=%h par=%b mark=%0d",
                 k, d, p, run, ok, e.d, e.p, gap);
      end
    end
  endtask
  task automatic bmon(input int k);
    int len, dn, t0;
    logic ab;
    forever begin
      @(negedge clk);
      if (busy[k] !== 1'b1) begin
        if (done[k] === 1'b1) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done_idle%0d: done=1 with busy=0", k);
        end
        continue;
      end
      len = 0;
      dn = 0;
      t0 = -1;
      ab = 1'b0;
      while (busy[k] === 1'b1 && len < 2000) begin
        if (rst[k]) ab = 1'b1;
        if (done[k] === 1'b1) dn++;
        if (t0 < 0 && tx[k] === 1'b0) t0 = len;
        len++;
        @(negedge clk);
      end
      sweeps[k]++;
      if (!ab) begin
        chk($sformatf("busy_len%0d", k), len, BL[k]);
        chk($sformatf("done_cnt%0d", k), dn, 1);
        chk($sformatf("start_lat%0d", k), t0, 2);
        chk($sformatf("done_after%0d", k), {31'd0, done[k]}, 0);
      end
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    fork
      mon(0); mon(1); mon(2);
      bmon(0); bmon(1); bmon(2);
    join_none
    if0.wr_en = 1'b0; if0.wr_addr = '0; if0.wr_data = '0;
    if1.wr_en = 1'b0; if1.wr_addr = '0; if1.wr_data = '0;
    if2.wr_en = 1'b0; if2.wr_addr = '0; if2.wr_data = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      btn = ~btn;
      tick();
      chk("rst_tx", {29'd0, tx}, 7);
      chk("rst_busy", {29'd0, busy}, 0);
      chk("rst_done", {29'd0, done}, 0);
    end
    btn = 3'b000;
    rst = 3'b000;
    repeat (40) tick();
    chk("no_sweep_after_rst", sweeps[0] + sweeps[1] + sweeps[2], 0);
    wr(0, 0, 8'h55); wr(0, 1, 8'hA3); wr(0, 2, 8'h00); wr(0, 3, 8'hFF);
    wr(1, 0, 8'h07); wr(1, 1, 8'h00); wr(1, 2, 8'h80); wr(1, 3, 8'hFE);
    wr(2, 0, 8'h07); wr(2, 1, 8'hFF); wr(2, 2, 8'h80); wr(2, 3, 8'h2A);
    push_a(8'hFF);
    press(0, 10);
    wait_idle(0);
    chk("sweeps_8n1", sweeps[0], 1);
    push(1, 8'h07, 1'b1, 1'b0);
    push(1, 8'h00, 1'b0, 1'b0);
    push(1, 8'h80, 1'b1, 1'b0);
    push(1, 8'hFE, 1'b1, 1'b1);
    press(1, 10);
    wait_idle(1);
    chk("sweeps_8e1", sweeps[1], 1);
    push(2, 8'h07, 1'b0, 1'b0);
    push(2, 8'h7F, 1'b0, 1'b0);
    push(2, 8'h00, 1'b1, 1'b0);
    push(2, 8'h2A, 1'b0, 1'b1);
    press(2, 10);
    wait_idle(2);
    chk("sweeps_7o2", sweeps[2], 1);
    press(0, 3);
    repeat (30) tick();
    chk("short_press_sweeps", sweeps[0], 1);
    chk("short_press_busy", {31'd0, busy[0]}, 0);
    push_a(8'hFF);
    btn[0] = 1'b1;
    repeat (250) tick();
    btn[0] = 1'b0;
    tick();
    chk("held_sweeps", sweeps[0], 2);
    push_a(8'hFF);
    press(0, 10);
    repeat (60) tick();
    press(0, 10);
    wait_idle(0);
    chk("second_press_sweeps", sweeps[0], 3);
    push_a(8'h3C);
    btn[0] = 1'b1;
    wait_busy(0);
    btn[0] = 1'b0;
    repeat (49) tick();
    wr(0, 3, 8'h3C);
    wait_idle(0);
    chk("write_sweeps", sweeps[0], 4);
    push_a(8'h3C);
    btn[0] = 1'b1;
    wait_busy(0);
    btn[0] = 1'b0;
    repeat (51) tick();
    rst[0] = 1'b1;
    tick();
    chk("abort_tx", {31'd0, tx[0]}, 1);
    chk("abort_busy", {31'd0, busy[0]}, 0);
    chk("abort_done", {31'd0, done[0]}, 0);
    rst[0] = 1'b0;
    repeat (100) tick();
    chk("abort_flushed", q[0].size(), 0);
    chk("abort_sweeps", sweeps[0], 5);
    push_a(8'h3C);
    press(0, 10);
    wait_idle(0);
    chk("restart_sweeps", sweeps[0], 6);
    for (int k = 0; k < 3; k++) chk($sformatf("queue_empty%0d", k), q[k].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_ram_tx.md
# uart_ram_tx

Parametrised UART transmitter that streams a small on-chip byte RAM out of `tx_out` when a push-button is pressed. It replaces the fixed 8N1, fixed-depth store-and-send top with configurable frame format (data bits, parity, stop bits), baud rate, RAM depth and button debounce. It adds a host write port for loading the RAM. It sits directly behind the board pin `tx_out` and the `BTNTX` pushbutton.

## Interface
- `RAM_SIZE`, 16, number of bytes in the store and bytes sent per press (≥2)
- `CLK_FREQ`, 44, clock frequency in MHz
- `BAUD`, 115200, line rate in bit/s
- `DATA_BITS`, 8, data bits per frame (5..8)
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even
- `STOP_BITS`, 1, 1 or 2
- `DB_CYCLES`, 16, consecutive stable-high cycles required to accept a button press
- `clk` in 1: single clock, 44 MHz nominal
- `rst` in 1: reset, synchronous, active-high
- `BTNTX` in 1: asynchronous pushbutton, active-high
- `wr_en` in 1: RAM write strobe
- `wr_addr` in $clog2(RAM_SIZE): RAM write address
- `wr_data` in 8: RAM write data
- `busy` out 1: sweep in progress
- `done` out 1: one-cycle pulse at end of sweep
- `tx_out` out 1: UART line, idle high

## Operation
- Button path:
  - 2-FF synchroniser, then a debounce counter.
  - Press event = synchronised level high for `DB_CYCLES` consecutive cycles after having been low; one event per press.
  - Events while `busy`=1 are discarded.
- RAM: `RAM_SIZE`×8, synchronous read, 1-cycle latency. Writes are accepted at any time, including during a sweep. A same-address read/write in one cycle returns the old data. RAM contents are not cleared by `rst`.
- Baud divisor: `BAUD_DIV` = (`CLK_FREQ`·1 000 000)/`BAUD`, integer truncation (44 MHz/115200 → 381). Every line bit lasts exactly `BAUD_DIV` cycles.
- FSM states: IDLE → FETCH → LOAD → START → DATA → [PARITY] → STOP → (FETCH | DONE) → IDLE.
  - IDLE: waits for a press event. On event: `rd_addr`=0, go to FETCH.
  - FETCH: drive `rd_addr`, 1 cycle.
  - LOAD: latch `ram_dout` into the shift register, 1 cycle.
  - START: `tx_out`=0.
  - DATA: `DATA_BITS` bits, LSB first. Bits above `DATA_BITS` are ignored.
  - PARITY: present only if `PARITY`≠0.
    - Odd: XOR of data bits, inverted.
    - Even: XOR of data bits.
  - STOP: `tx_out`=1 for `STOP_BITS`·`BAUD_DIV` cycles. Then increment `rd_addr`: go to FETCH if more bytes remain, else DONE.
  - DONE: `done`=1 for 1 cycle, then IDLE.
- Address wraps to 0 only at the start of a new sweep. Each sweep sends addresses 0..`RAM_SIZE`-1 exactly once.
- `tx_out`=1 in IDLE, FETCH, LOAD and DONE.

## Timing
- Reset values: `tx_out`=1, `busy`=0, `done`=0, FSM=IDLE, `rd_addr`=0, debounce counter 0, synchroniser 0.
- `rst` mid-sweep: outputs take their reset values on the next edge. The frame is aborted and the next press restarts at address 0.
- Press event registered at cycle E:
  - `busy`=1 from E+1.
  - First start-bit falling edge at E+3.
- Frame length: `BAUD_DIV`·(1+`DATA_BITS`+(`PARITY`≠0)+`STOP_BITS`) cycles.
- Inter-byte mark gap: exactly 2 cycles (FETCH+LOAD) added to the stop bits.
- `done` is high on the cycle after the last stop-bit cycle. `busy` falls with `done`, so `busy`=0 on the following cycle.
- Total `busy` duration = `RAM_SIZE`·(frame+2)+1 cycles.
- `done` never coincides with `busy`=0 and is never asserted outside a sweep.

## Test plan
Unless stated: `CLK_FREQ`=1, `BAUD`=250000 (`BAUD_DIV`=4), `RAM_SIZE`=4, `DB_CYCLES`=4.

- Reset: hold `rst` 5 cycles while toggling `BTNTX` → `tx_out`=1, `busy`=0, `done`=0 throughout. No frame is sent after release.
- 8N1 sweep: load 0x55, 0xA3, 0x00, 0xFF, then press → `tx_out` bits (4 cycles each):
  - Byte 0 (0x55): start 0, then 1,0,1,0,1,0,1,0, stop 1.
  - Bytes 1–3 follow in address order with 2-cycle gaps.
  - `busy` high 169 cycles; one `done` pulse.
- Parity: `PARITY`=2, byte 0x07 → parity bit 1. `PARITY`=1, byte 0x07 → parity bit 0. Frame is 44 cycles.
- Format: `DATA_BITS`=7, `STOP_BITS`=2, byte 0xFF → 7 data ones, stop high 8 cycles, 0x80 bit never sent.
- Debounce and busy:
  - `BTNTX` high 3 cycles → no sweep.
  - Button held through an entire sweep → exactly one sweep.
  - Second press mid-sweep → ignored.
- Abort and write-during-sweep:
  - `rst` during byte 1's data bits → `tx_out`=1 next cycle, `busy`=0. Re-press restarts at address 0.
  - Write 0x3C to address 3 during byte 1 → 0x3C is transmitted as byte 3.
